loader_stream_master: RTL
=========================

// Module: loader_stream_master
// PURPOSE
//   Drives the ROM loader bus: loader_act, loader_a[31:0], loader_d, loader_wr.
//   Sound and ROM consumers (GS SDRAM image, etc.) sample this bus.
//   Parses a byte-wide command stream from the MCU link and turns it into paced
//   single-byte write strobes. Sits in the clk_sys domain between the MCU byte
//   receiver and every loader-bus consumer.
// PARAMETERS
//   WR_CYCLES   2  cycles loader_wr is held high per byte (>=1)
//   GAP_CYCLES  4  idle cycles after loader_wr falls before next byte accepted (>=1)
// PORTS
//   clk_sys     in   1   system clock
//   areset_n    in   1   asynchronous reset, active low
//   rx_valid    in   1   rx_data holds a byte
//   rx_data     in   8   command/payload byte
//   rx_ready    out  1   byte accepted when rx_valid & rx_ready in the same cycle
//   loader_act  out  1   loading session active
//   loader_a    out  32  write address; bit 31 selects the GS ROM region downstream
//   loader_d    out  8   write data
//   loader_wr   out  1   write strobe
//   busy        out  1   state != IDLE
//   err         out  1   sticky protocol error, cleared by CMD_START
// BEHAVIOUR
//   Reset (async, areset_n=0): all outputs 0, state IDLE; err=0. Applies mid-write too:
//     loader_wr and loader_act drop the same instant, and any partial packet is discarded.
//   Commands (decoded only in IDLE):
//     0x01 START - loader_act<=1, err<=0
//     0x02 ADDR  - next 4 bytes, big-endian, load loader_a
//     0x03 DATA  - next byte is len N (0 means 256), then N data bytes
//     0x04 END   - loader_act<=0
//     other      - err<=1, byte dropped, stay IDLE
//   States: IDLE, ADDR (2-bit byte idx), LEN, DATA, WR, GAP, [CHK].
//   rx_ready=1 in IDLE/ADDR/LEN/DATA/CHK; rx_ready=0 in WR/GAP.
//   Address load: loader_a updates atomically after the 4th byte; it is never partially visible.
//   Write cycle:
//     - DATA accepts a byte: loader_d<=byte, -> WR.
//     - WR: loader_wr=1 for exactly WR_CYCLES cycles; loader_a and loader_d stay stable.
//     - GAP: loader_wr=0 for GAP_CYCLES cycles; loader_a+=1 on GAP entry (32-bit wrap FFFFFFFF->0).
//     - Remaining count >0 -> DATA, else -> IDLE (or CHK).
//   Latency: accept-to-loader_wr rise = 1 cycle.
//     Byte period = 1 + WR_CYCLES + GAP_CYCLES cycles at full rate.
//   DATA while loader_act=0: payload consumed and discarded, no loader_wr pulse, err<=1.
//   rx_valid low in ADDR/LEN/DATA: wait indefinitely, no timeout.
//   Counter: 9-bit remaining count, so len 0 yields exactly 256 writes.
// CONFIGURATION
//   LOADER_STREAM_CSUM_EN defined:
//     - after the last data byte, state CHK accepts one byte.
//     - that byte is compared with the XOR of all N payload bytes (discarded payloads count too).
//     - mismatch sets err<=1.
//     - -> IDLE after the compare.
//   LOADER_STREAM_CSUM_EN undefined: no CHK state; the byte after the payload decodes as a command.
// TESTING
//   1. Reset: areset_n=0 mid-WR
//      -> loader_wr, loader_act, busy, rx_ready all 0 immediately.
//      After release: IDLE, rx_ready=1.
//   2. 01, 02 80 00 00 10, 03 03 AA BB CC, 04
//      -> three loader_wr pulses of WR_CYCLES each.
//      -> (a,d) = (80000010,AA) (80000011,BB) (80000012,CC).
//      -> loader_act high only between 01 and 04; err=0.
//   3. Back-to-back rx_valid during payload
//      -> rx_ready low exactly WR_CYCLES+GAP_CYCLES cycles per byte; no byte lost or duplicated.
//   4. ADDR FFFFFFFF, DATA len 2 (11,22)
//      -> writes at FFFFFFFF then 00000000.
//      -> len 00 with 256 bytes -> exactly 256 strobes.
//   5. Byte 0x7E in IDLE -> err=1.
//      Then DATA before START -> no strobe, err stays 1.
//      Then 01 -> err=0.
//   6. CSUM_EN: payload 12 34, check byte 26 -> err=0.
//      Same payload with check byte 27 -> err=1.
//      Without CSUM_EN, the byte after the payload is decoded as a command.

Source files
------------

// File: rtl/loader_stream_master.sv
// Turns the byte-wide MCU command stream into paced single-byte loader-bus writes.
// Optional trailing XOR checksum byte per DATA packet: define LOADER_STREAM_CSUM_EN.
module loader_stream_master #(
    parameter int WR_CYCLES  = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk_sys,
    input  logic        areset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        loader_act,
    output logic [31:0] loader_a,
    output logic [7:0]  loader_d,
    output logic        loader_wr,
    output logic        busy,
    output logic        err
);

    localparam int CMAX = (WR_CYCLES > GAP_CYCLES) ? WR_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_WR,
        S_GAP
`ifdef LOADER_STREAM_CSUM_EN
        , S_CHK
`endif
    } state_t;

`ifdef LOADER_STREAM_CSUM_EN
    localparam state_t AFTER_PAYLOAD = S_CHK;
`else
    localparam state_t AFTER_PAYLOAD = S_IDLE;
`endif

    state_t        state;
    state_t        next_state;
    logic          ready_c;
    logic          accept;
    logic [1:0]    addr_idx;
    logic [23:0]   addr_shift;
    logic [8:0]    remaining;
    logic [CW-1:0] cnt;
`ifdef LOADER_STREAM_CSUM_EN
    logic [7:0]    csum;
`endif

    // Ready is forced low while reset is held so the link never sees a handshake during reset.
    assign rx_ready = ready_c & areset_n;
    assign accept   = rx_valid & ready_c;
    assign busy     = (state != S_IDLE);

    always_comb begin
        next_state = state;
        ready_c    = 1'b0;
        case (state)
            S_IDLE: begin
                ready_c = 1'b1;
                if (rx_valid && rx_data == 8'h02) next_state = S_ADDR;
                if (rx_valid && rx_data == 8'h03) next_state = S_LEN;
            end
            S_ADDR: begin
                ready_c = 1'b1;
                if (rx_valid && addr_idx == 2'd3) next_state = S_IDLE;
            end
            S_LEN: begin
                ready_c = 1'b1;
                if (rx_valid) next_state = S_DATA;
            end
            S_DATA: begin
                ready_c = 1'b1;
                if (rx_valid) begin
                    if (loader_act)              next_state = S_WR;
                    else if (remaining == 9'd1)  next_state = AFTER_PAYLOAD;
                end
            end
            S_WR: begin
                if (cnt == CW'(WR_CYCLES - 1)) next_state = S_GAP;
            end
            S_GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1))
                    next_state = (remaining != 9'd0) ? S_DATA : AFTER_PAYLOAD;
            end
`ifdef LOADER_STREAM_CSUM_EN
            S_CHK: begin
                ready_c = 1'b1;
                if (rx_valid) next_state = S_IDLE;
            end
`endif
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge areset_n) begin
        if (!areset_n) state <= S_IDLE;
        else           state <= next_state;
    end

    // Datapath: the pacing counter restarts on every state change.
    always_ff @(posedge clk_sys or negedge areset_n) begin
        if (!areset_n) begin
            loader_act <= 1'b0;
            loader_a   <= '0;
            loader_d   <= '0;
            loader_wr  <= 1'b0;
            err        <= 1'b0;
            addr_idx   <= '0;
            addr_shift <= '0;
            remaining  <= '0;
            cnt        <= '0;
`ifdef LOADER_STREAM_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            loader_wr <= (next_state == S_WR);
            cnt       <= (state != next_state) ? '0 : cnt + CW'(1);
            if (state == S_WR && next_state == S_GAP) loader_a <= loader_a + 32'd1;
            if (accept) begin
                case (state)
                    S_IDLE: begin
                        case (rx_data)
                            8'h01: begin loader_act <= 1'b1; err <= 1'b0; end
                            8'h02: addr_idx <= '0;
                            8'h03: ;
                            8'h04: loader_act <= 1'b0;
                            default: err <= 1'b1;
                        endcase
                    end
                    S_ADDR: begin
                        addr_shift <= {addr_shift[15:0], rx_data};
                        addr_idx   <= addr_idx + 2'd1;
                        if (addr_idx == 2'd3) loader_a <= {addr_shift, rx_data};
                    end
                    S_LEN: begin
                        remaining <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
`ifdef LOADER_STREAM_CSUM_EN
                        csum      <= '0;
`endif
                    end
                    S_DATA: begin
                        remaining <= remaining - 9'd1;
`ifdef LOADER_STREAM_CSUM_EN
                        csum      <= csum ^ rx_data;
`endif
                        if (loader_act) loader_d <= rx_data;
                        else            err      <= 1'b1;
                    end
`ifdef LOADER_STREAM_CSUM_EN
                    S_CHK: begin
                        if (rx_data != csum) err <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
